cordic_iterative_core: RTL
==========================

// Module: cordic_iterative_core
// PURPOSE
//  Parametrised, handshaked CORDIC engine: one shared datapath, one micro-rotation per clock.
//  Successor to the fixed pipeline top: adds a per-transaction rotation/vectoring mode,
//  quadrant pre-rotation with a reported flip flag, saturating output and valid/ready handshakes.
//  Sits between interface_input (upstream) and interface_output (downstream).
// PARAMETERS
//  INPUT_WIDTH 16 : in_x/in_y/in_z width, signed Q(INPUT_INT_WIDTH).(INPUT_FRAC_WIDTH)
//  INPUT_INT_WIDTH 7 / INPUT_FRAC_WIDTH 8 : input integer/fraction bits (sign bit extra)
//  OUTPUT_WIDTH 16, OUTPUT_INT_WIDTH 7, OUTPUT_FRAC_WIDTH 8 : output format, same rule
//  ITERATION_NUMBER 6 : micro-rotations per transaction, legal 1..16
//  ITERATION_WORD_WIDTH 32 (INT 12, FRAC 20) : internal signed x/y/z register format
//  FLIP_FLAG_WIDTH 2 : width of out_flip
// PORTS
//  clk        in  1   clock, all state on rising edge
//  rst_n      in  1   asynchronous active-low reset
//  in_valid   in  1   input operands valid
//  in_ready   out 1   core can accept (IDLE only)
//  in_mode    in  1   0 = rotation (drive z->0), 1 = vectoring (drive y->0)
//  in_x/in_y  in  INPUT_WIDTH  signed vector components
//  in_z       in  INPUT_WIDTH  signed angle, radians
//  out_valid  out 1   result valid, held until accepted
//  out_ready  in  1   downstream accepts
//  out_x/out_y/out_z out OUTPUT_WIDTH  results (x/y include CORDIC gain An, no compensation)
//  out_flip   out FLIP_FLAG_WIDTH  00 none, 01 pre-rotated -pi/2 (z+=pi/2), 10 pre-rotated +pi/2 (z-=pi/2)
//  out_ovf    out 1   any of out_x/y/z saturated
//  busy       out 1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, out_x/y/z=0, out_flip=00, out_ovf=0, busy=0, counter=0.
//  FSM: IDLE -(in_valid&&in_ready)-> PRE -> ITER (N cycles) -> DONE -(out_ready)-> IDLE.
//   out_valid rises exactly ITERATION_NUMBER+2 cycles after the accepting edge; in_ready=0 outside IDLE.
//   In DONE, outputs/flags stay stable while out_valid && !out_ready; mode/operands latched at accept.
//  Load: sign-extend integer part to 12 bits, zero-pad fraction to 20 bits.
//  PRE (latched mode):
//   rotation:  z>pi/2 -> (x,y)=(-y,x), z-=pi/2, flip=10; z<-pi/2 -> (x,y)=(y,-x), z+=pi/2, flip=01.
//   vectoring: x<0,y>=0 -> (x,y)=(y,-x), z+=pi/2, flip=01; x<0,y<0 -> (x,y)=(-y,x), z-=pi/2, flip=10.
//   Otherwise unchanged, flip=00. pi/2 is a Q12.20 constant (round-to-nearest).
//  ITER i=0..N-1: d=+1 if (rotation ? z>=0 : y<0) else -1;
//   x'=x-d*(y>>>i), y'=y+d*(x>>>i), z'=z-d*atan(2^-i); >>> arithmetic, all updates use old x/y/z.
//   atan table: 16 Q12.20 constants, rounded to nearest; internal adds wrap (range never exceeded for legal inputs).
//  DONE entry: each word -> output format: drop 12 low frac bits (floor), saturate to
//   [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1]; out_ovf = OR of the three saturations.
//  Simultaneous: in_valid while busy is ignored (no accept); out_ready while out_valid=0 ignored.
//  rst_n low mid-transaction: aborts immediately, returns to reset values, no out_valid emitted.
//  New accept possible on the cycle after DONE->IDLE (1 bubble); throughput 1 per N+3 cycles.
// TESTING (N=6, An~=1.6465, tolerance +/-0.06 on results)
//  1 rotation x=0x0100(1.0),y=0,z=0x0080(0.5) -> after 8 cycles out_x~=1.445, out_y~=0.789, out_z~=0, flip=00.
//  2 vectoring x=0x0300,y=0x0400 -> out_x~=8.23, out_y~=0, out_z~=0.927(~0x00ED), flip=00, ovf=0.
//  3 vectoring x=0xFF00(-1),y=0 -> flip=01, out_z~=pi(~0x0324), out_x~=1.6465; rotation z=0x0200(2.0) -> flip=10.
//  4 vectoring x=y=0x6400(100) -> out_x=0x7FFF, out_ovf=1; next non-overflowing transaction clears out_ovf.
//  5 backpressure: out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; release -> one transfer.
//  6 rst_n low during ITER cycle 3 -> all outputs to reset values at once; fresh transaction afterwards matches test 1.

Source files
------------

// File: rtl/cordic_iterative_core.sv
// Iterative CORDIC engine: one shared add/shift datapath, one micro-rotation per clock.
// Valid/ready handshakes on both sides, quadrant pre-rotation reported on out_flip,
// and outputs saturated to the output format with a sticky-per-result overflow flag.
module cordic_iterative_core #(
    parameter int INPUT_WIDTH               = 16,
    parameter int INPUT_INT_WIDTH           = 7,
    parameter int INPUT_FRAC_WIDTH          = 8,
    parameter int OUTPUT_WIDTH              = 16,
    parameter int OUTPUT_INT_WIDTH          = 7,
    parameter int OUTPUT_FRAC_WIDTH         = 8,
    parameter int ITERATION_NUMBER          = 6,
    parameter int ITERATION_WORD_WIDTH      = 32,
    parameter int ITERATION_WORD_INT_WIDTH  = 12,
    parameter int ITERATION_WORD_FRAC_WIDTH = 20,
    parameter int FLIP_FLAG_WIDTH           = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_mode,
    input  logic [INPUT_WIDTH-1:0]     in_x,
    input  logic [INPUT_WIDTH-1:0]     in_y,
    input  logic [INPUT_WIDTH-1:0]     in_z,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUTPUT_WIDTH-1:0]    out_x,
    output logic [OUTPUT_WIDTH-1:0]    out_y,
    output logic [OUTPUT_WIDTH-1:0]    out_z,
    output logic [FLIP_FLAG_WIDTH-1:0] out_flip,
    output logic                       out_ovf,
    output logic                       busy
);

    localparam int WW      = ITERATION_WORD_WIDTH;
    // Sign bits added above the input integer part, zero bits added below its fraction.
    localparam int EXT     = ITERATION_WORD_INT_WIDTH - INPUT_INT_WIDTH - 1;
    localparam int PAD     = ITERATION_WORD_FRAC_WIDTH - INPUT_FRAC_WIDTH;
    // Fraction bits discarded (floor) when converting back to the output format.
    localparam int DROP    = ITERATION_WORD_FRAC_WIDTH - OUTPUT_FRAC_WIDTH;
    localparam int OUT_MAG = OUTPUT_INT_WIDTH + OUTPUT_FRAC_WIDTH;
    localparam int CW      = $clog2(ITERATION_NUMBER + 1);

    localparam logic signed [WW-1:0] HALF_PI   = WW'(32'sd1647099);
    localparam logic signed [WW-1:0] OUT_MAX_W = {{(WW-OUT_MAG){1'b0}}, {OUT_MAG{1'b1}}};
    localparam logic signed [WW-1:0] OUT_MIN_W = {{(WW-OUT_MAG){1'b1}}, {OUT_MAG{1'b0}}};

    localparam logic [FLIP_FLAG_WIDTH-1:0] FLIP_NONE = '0;
    localparam logic [FLIP_FLAG_WIDTH-1:0] FLIP_NEG  = FLIP_FLAG_WIDTH'(1); // pre-rotated -pi/2
    localparam logic [FLIP_FLAG_WIDTH-1:0] FLIP_POS  = FLIP_FLAG_WIDTH'(2); // pre-rotated +pi/2

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
        S_DONE
    } state_e;

    state_e                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         mode_q, mode_d;
    logic signed [WW-1:0]         x_q, x_d, y_q, y_d, z_q, z_d;
    logic [FLIP_FLAG_WIDTH-1:0]   flip_q, flip_d;
    logic [OUTPUT_WIDTH-1:0]      out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
    logic [FLIP_FLAG_WIDTH-1:0]   out_flip_q, out_flip_d;
    logic                         ovf_q, ovf_d;

    logic [OUTPUT_WIDTH:0]        conv_x, conv_y, conv_z;
    logic signed [WW-1:0]         x_sh, y_sh, atan_i;
    logic                         d_pos;

    // atan(2^-i) in Q12.20, rounded to nearest.
    function automatic logic signed [31:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 32'sd823550;
            4'd1:    atan_lut = 32'sd486170;
            4'd2:    atan_lut = 32'sd256879;
            4'd3:    atan_lut = 32'sd130396;
            4'd4:    atan_lut = 32'sd65451;
            4'd5:    atan_lut = 32'sd32757;
            4'd6:    atan_lut = 32'sd16383;
            4'd7:    atan_lut = 32'sd8192;
            4'd8:    atan_lut = 32'sd4096;
            4'd9:    atan_lut = 32'sd2048;
            4'd10:   atan_lut = 32'sd1024;
            4'd11:   atan_lut = 32'sd512;
            4'd12:   atan_lut = 32'sd256;
            4'd13:   atan_lut = 32'sd128;
            4'd14:   atan_lut = 32'sd64;
            default: atan_lut = 32'sd32;
        endcase
    endfunction

    // Input word -> internal word: sign-extend the integer part, zero-pad the fraction.
    function automatic logic signed [WW-1:0] load_word(input logic [INPUT_WIDTH-1:0] v);
        load_word = {{EXT{v[INPUT_WIDTH-1]}}, v, {PAD{1'b0}}};
    endfunction

    // Internal word -> {saturated, output word}: floor the extra fraction bits, then clamp.
    function automatic logic [OUTPUT_WIDTH:0] to_output(input logic signed [WW-1:0] w);
        logic signed [WW-1:0] s;
        s = w >>> DROP;
        if (s > OUT_MAX_W) begin
            to_output = {1'b1, OUT_MAX_W[OUTPUT_WIDTH-1:0]};
        end else if (s < OUT_MIN_W) begin
            to_output = {1'b1, OUT_MIN_W[OUTPUT_WIDTH-1:0]};
        end else begin
            to_output = {1'b0, s[OUTPUT_WIDTH-1:0]};
        end
    endfunction

    assign conv_x = to_output(x_q);
    assign conv_y = to_output(y_q);
    assign conv_z = to_output(z_q);

    // Shared micro-rotation operands: both shifts and the table read use the same step index.
    assign x_sh   = x_q >>> cnt_q;
    assign y_sh   = y_q >>> cnt_q;
    assign atan_i = WW'(atan_lut(4'(cnt_q)));
    assign d_pos  = mode_q ? y_q[WW-1] : ~z_q[WW-1];

    // Next-state and datapath: load on accept, pre-rotate, iterate, convert, hold until taken.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        flip_d     = flip_q;
        out_x_d    = out_x_q;
        out_y_d    = out_y_q;
        out_z_d    = out_z_q;
        out_flip_d = out_flip_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mode_d  = in_mode;
                    x_d     = load_word(in_x);
                    y_d     = load_word(in_y);
                    z_d     = load_word(in_z);
                    cnt_d   = '0;
                    state_d = S_PRE;
                end
            end

            S_PRE: begin
                flip_d = FLIP_NONE;
                if (!mode_q) begin
                    // Rotation: bring the target angle into [-pi/2, pi/2].
                    if (z_q > HALF_PI) begin
                        x_d    = -y_q;
                        y_d    = x_q;
                        z_d    = z_q - HALF_PI;
                        flip_d = FLIP_POS;
                    end else if (z_q < -HALF_PI) begin
                        x_d    = y_q;
                        y_d    = -x_q;
                        z_d    = z_q + HALF_PI;
                        flip_d = FLIP_NEG;
                    end
                end else if (x_q[WW-1]) begin
                    // Vectoring: move a left-half-plane vector into the right half-plane.
                    if (!y_q[WW-1]) begin
                        x_d    = y_q;
                        y_d    = -x_q;
                        z_d    = z_q + HALF_PI;
                        flip_d = FLIP_NEG;
                    end else begin
                        x_d    = -y_q;
                        y_d    = x_q;
                        z_d    = z_q - HALF_PI;
                        flip_d = FLIP_POS;
                    end
                end
                cnt_d   = '0;
                state_d = S_ITER;
            end

            S_ITER: begin
                if (cnt_q == CW'(ITERATION_NUMBER)) begin
                    // All micro-rotations done: convert and saturate into the output registers.
                    out_x_d    = conv_x[OUTPUT_WIDTH-1:0];
                    out_y_d    = conv_y[OUTPUT_WIDTH-1:0];
                    out_z_d    = conv_z[OUTPUT_WIDTH-1:0];
                    ovf_d      = conv_x[OUTPUT_WIDTH] | conv_y[OUTPUT_WIDTH] | conv_z[OUTPUT_WIDTH];
                    out_flip_d = flip_q;
                    cnt_d      = '0;
                    state_d    = S_DONE;
                end else begin
                    if (d_pos) begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - atan_i;
                    end else begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + atan_i;
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State register: asynchronous reset returns the FSM to IDLE at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Datapath and output registers, all cleared by reset so an aborted transaction leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            flip_q     <= FLIP_NONE;
            out_x_q    <= '0;
            out_y_q    <= '0;
            out_z_q    <= '0;
            out_flip_q <= FLIP_NONE;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            flip_q     <= flip_d;
            out_x_q    <= out_x_d;
            out_y_q    <= out_y_d;
            out_z_q    <= out_z_d;
            out_flip_q <= out_flip_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;
    assign out_flip  = out_flip_q;
    assign out_ovf   = ovf_q;

endmodule
